// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
//
// Purpose:
//    Single-entry operand register between decode and execute. It captures an
//    instruction from decode and holds it until the execute stage consumes it.
//    It forms the A/B operands and shift amount for the ALU/shifter. When
//    forwarding is built in, operands are resolved against the EX/MEM and
//    MEM/WB result buses at capture. While stalled, the held operands keep
//    snooping the MEM/WB bus so a late writeback is not missed.
//
// Configuration:
//    EX_OPERAND_FWD_EN  - when defined, enables capture-time forwarding (MEM
//                         has priority over WB, x0 always reads 0) and
//                         stall-time WB snooping. When undefined, the register
//                         file data is captured raw, and the mem_* and wb_*
//                         ports are present but ignored.
//
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    in_valid / in_ready        decode handshake (in_ready is combinational)
//    in_pc, in_imm              PC and sign-extended immediate
//    in_rs1, in_rs2, in_rd      register addresses
//    in_rs1_data, in_rs2_data   register-file read data
//    in_sel                     op code (1000 SRL, 1001 SLL, 1010 SRA, else ALU)
//    in_use_imm, in_reg_write   B-operand select, writeback enable
//    flush                      kill held and incoming instruction
//    mem_we, mem_rd, mem_data   EX/MEM forwarding source
//    wb_we, wb_rd, wb_data      MEM/WB forwarding source
//    out_valid / out_ready      execute handshake
//    out_a, out_b, out_shamt    operands and shift amount (out_b[4:0])
//    out_sel, out_rd            op code and destination register
//    out_reg_write, out_pc      writeback enable (0 when empty), PC
// -----------------------------------------------------------------------------
module ex_operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [3:0]  in_sel,
   input  logic        in_use_imm,
   input  logic        in_reg_write,
   input  logic        flush,
   input  logic        mem_we,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_shamt,
   output logic [3:0]  out_sel,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic [31:0] out_pc
);

   // Held instruction.
   logic        held_valid;
   logic [31:0] held_rs1_val;
   logic [31:0] held_rs2_val;
   logic [31:0] held_imm;
   logic [31:0] held_pc;
   logic        held_use_imm;
   logic        held_reg_write;
   logic [3:0]  held_sel;
   logic [4:0]  held_rd;

   logic        capture;
   logic        stalled;
   logic [31:0] next_rs1_val;
   logic [31:0] next_rs2_val;

   // The entry may be refilled in the same cycle it is consumed. A flush
   // always blocks capture.
   assign in_ready = (!held_valid || out_ready) && !flush;
   assign capture  = in_valid && in_ready;

   // Stalled means the entry survives this edge with unchanged ownership.
   // This is the only window in which WB snooping is meaningful.
   assign stalled  = held_valid && !out_ready && !flush;

`ifdef EX_OPERAND_FWD_EN
   logic [4:0]  held_rs1;
   logic [4:0]  held_rs2;
   logic [31:0] fwd_rs1_val;
   logic [31:0] fwd_rs2_val;
   logic        snoop_rs1;
   logic        snoop_rs2;

   // Operand resolution: x0 is hard-wired to zero and never forwarded. The
   // younger EX/MEM result beats the older MEM/WB result.
   function automatic logic [31:0] resolve_operand(
      input logic [4:0]  addr,
      input logic [31:0] rf_data,
      input logic        m_we,
      input logic [4:0]  m_rd,
      input logic [31:0] m_data,
      input logic        w_we,
      input logic [4:0]  w_rd,
      input logic [31:0] w_data
   );
      logic [31:0] result;
      result = rf_data;
      if (addr == 5'd0) begin
         result = 32'd0;
      end else if (m_we && (m_rd == addr)) begin
         result = m_data;
      end else if (w_we && (w_rd == addr)) begin
         result = w_data;
      end
      return result;
   endfunction

   assign fwd_rs1_val = resolve_operand(in_rs1, in_rs1_data, mem_we, mem_rd,
                                        mem_data, wb_we, wb_rd, wb_data);
   assign fwd_rs2_val = resolve_operand(in_rs2, in_rs2_data, mem_we, mem_rd,
                                        mem_data, wb_we, wb_rd, wb_data);

   // A writeback that lands while the instruction waits must still reach it.
   // Only WB is snooped: it is the last point where a result becomes
   // architecturally visible before the register file.
   assign snoop_rs1 = stalled && wb_we && (wb_rd == held_rs1) && (held_rs1 != 5'd0);
   assign snoop_rs2 = stalled && wb_we && (wb_rd == held_rs2) && (held_rs2 != 5'd0);

   always_comb begin
      next_rs1_val = held_rs1_val;
      next_rs2_val = held_rs2_val;
      if (capture) begin
         next_rs1_val = fwd_rs1_val;
         next_rs2_val = fwd_rs2_val;
      end else begin
         if (snoop_rs1) begin
            next_rs1_val = wb_data;
         end
         if (snoop_rs2) begin
            next_rs2_val = wb_data;
         end
      end
   end

   // Source addresses are kept only so the held operands can be snooped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_rs1 <= 5'd0;
         held_rs2 <= 5'd0;
      end else if (capture) begin
         held_rs1 <= in_rs1;
         held_rs2 <= in_rs2;
      end
   end
`else
   // Forwarding hardware is absent. These inputs are reduced here only so
   // that they have a reader.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{in_rs1, in_rs2, mem_we, mem_rd, mem_data,
                                wb_we, wb_rd, wb_data};

   always_comb begin
      next_rs1_val = held_rs1_val;
      next_rs2_val = held_rs2_val;
      if (capture) begin
         next_rs1_val = in_rs1_data;
         next_rs2_val = in_rs2_data;
      end
   end
`endif

   // Entry occupancy and payload. flush and capture are mutually exclusive
   // because in_ready is low during a flush. Payload fields other than the
   // operands change only on capture, so they hold after the entry empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_valid     <= 1'b0;
         held_rs1_val   <= 32'd0;
         held_rs2_val   <= 32'd0;
         held_imm       <= 32'd0;
         held_pc        <= 32'd0;
         held_use_imm   <= 1'b0;
         held_reg_write <= 1'b0;
         held_sel       <= 4'd0;
         held_rd        <= 5'd0;
      end else begin
         if (flush) begin
            held_valid <= 1'b0;
         end else if (capture) begin
            held_valid <= 1'b1;
         end else if (out_ready) begin
            held_valid <= 1'b0;
         end

         held_rs1_val <= next_rs1_val;
         held_rs2_val <= next_rs2_val;

         if (capture) begin
            held_imm       <= in_imm;
            held_pc        <= in_pc;
            held_use_imm   <= in_use_imm;
            held_reg_write <= in_reg_write;
            held_sel       <= in_sel;
            held_rd        <= in_rd;
         end
      end
   end

   assign out_valid     = held_valid;
   assign out_a         = held_rs1_val;
   assign out_b         = held_use_imm ? held_imm : held_rs2_val;
   assign out_shamt     = out_b[4:0];
   assign out_sel       = held_sel;
   assign out_rd        = held_rd;
   assign out_pc        = held_pc;
   // An empty entry must never request a register write.
   assign out_reg_write = held_valid && held_reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Self-checking bench for ex_operand_stage. It uses a table of single-capture
// vectors, directed multi-cycle sequences (stall, flush, reset mid-stall,
// forwarding/snoop), and a randomized run against a record-level model of the
// stage. Honours EX_OPERAND_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [3:0]  in_sel;
   logic        in_use_imm;
   logic        in_reg_write;
   logic        flush;
   logic        mem_we;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_shamt;
   logic [3:0]  out_sel;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic [31:0] out_pc;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_sel(in_sel), .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
      .flush(flush),
      .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
      .out_sel(out_sel), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_pc(out_pc)
   );

   typedef struct {
      logic        in_valid;
      logic        out_ready;
      logic        flush;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [3:0]  sel;
      logic        use_imm;
      logic        reg_write;
      logic        mem_we;
      logic [4:0]  mem_rd;
      logic [31:0] mem_data;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } stim_t;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_write;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [4:0]  exp_shamt;
      logic        exp_rw;
   } vec_t;

   // Reference model: one instruction record plus its occupancy flag.
   typedef struct {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b_reg;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        use_imm;
      logic        reg_write;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } slot_t;

   slot_t m = '{default: 0};
   stim_t s;
   vec_t  vecs[5];

   function automatic logic model_in_ready(input slot_t cur);
      return (!cur.valid || out_ready) && !flush;
   endfunction

`ifdef EX_OPERAND_FWD_EN
   function automatic logic [31:0] operand_rule(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 5'd0) return 32'd0;
      if (mem_we && mem_rd == addr) return mem_data;
      if (wb_we && wb_rd == addr) return wb_data;
      return rf;
   endfunction
`endif

   function automatic slot_t model_next(input slot_t cur);
      slot_t n;
      n = cur;
      if (in_valid && model_in_ready(cur)) begin
         n.valid     = 1'b1;
`ifdef EX_OPERAND_FWD_EN
         n.a         = operand_rule(in_rs1, in_rs1_data);
         n.b_reg     = operand_rule(in_rs2, in_rs2_data);
`else
         n.a         = in_rs1_data;
         n.b_reg     = in_rs2_data;
`endif
         n.imm       = in_imm;
         n.pc        = in_pc;
         n.use_imm   = in_use_imm;
         n.reg_write = in_reg_write;
         n.sel       = in_sel;
         n.rd        = in_rd;
         n.rs1       = in_rs1;
         n.rs2       = in_rs2;
      end else if (flush) begin
         n.valid = 1'b0;
      end else if (cur.valid && out_ready) begin
         n.valid = 1'b0;
      end else if (cur.valid) begin
`ifdef EX_OPERAND_FWD_EN
         if (wb_we && wb_rd == cur.rs1 && cur.rs1 != 5'd0) n.a = wb_data;
         if (wb_we && wb_rd == cur.rs2 && cur.rs2 != 5'd0) n.b_reg = wb_data;
`endif
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{default: 0};
      else        m <= model_next(m);
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] exp_b;
      exp_b = m.use_imm ? m.imm : m.b_reg;
      checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(m.valid));
      checkVal({tag, ".out_a"}, out_a, m.a);
      checkVal({tag, ".out_b"}, out_b, exp_b);
      checkVal({tag, ".out_shamt"}, 32'(out_shamt), 32'(exp_b[4:0]));
      checkVal({tag, ".out_sel"}, 32'(out_sel), 32'(m.sel));
      checkVal({tag, ".out_rd"}, 32'(out_rd), 32'(m.rd));
      checkVal({tag, ".out_reg_write"}, 32'(out_reg_write), 32'(m.valid && m.reg_write));
      checkVal({tag, ".out_pc"}, out_pc, m.pc);
   endtask

   task automatic checkZero(input string tag);
      checkVal({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      checkVal({tag, ".out_reg_write"}, 32'(out_reg_write), 32'd0);
      checkVal({tag, ".out_a"}, out_a, 32'd0);
      checkVal({tag, ".out_b"}, out_b, 32'd0);
      checkVal({tag, ".out_pc"}, out_pc, 32'd0);
      checkVal({tag, ".out_sel"}, 32'(out_sel), 32'd0);
      checkVal({tag, ".out_rd"}, 32'(out_rd), 32'd0);
      checkVal({tag, ".out_shamt"}, 32'(out_shamt), 32'd0);
   endtask

   task automatic applyStimulus(input stim_t st);
      in_valid     = st.in_valid;
      out_ready    = st.out_ready;
      flush        = st.flush;
      in_pc        = st.pc;
      in_imm       = st.imm;
      in_rs1       = st.rs1;
      in_rs2       = st.rs2;
      in_rd        = st.rd;
      in_rs1_data  = st.rs1_data;
      in_rs2_data  = st.rs2_data;
      in_sel       = st.sel;
      in_use_imm   = st.use_imm;
      in_reg_write = st.reg_write;
      mem_we       = st.mem_we;
      mem_rd       = st.mem_rd;
      mem_data     = st.mem_data;
      wb_we        = st.wb_we;
      wb_rd        = st.wb_rd;
      wb_data      = st.wb_data;
   endtask

   function automatic stim_t idle_stim();
      stim_t st;
      st = '{default: 0};
      st.out_ready = 1'b1;
      st.rs1 = 5'd1;
      st.rs2 = 5'd2;
      return st;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_fwd_mem, exp_fwd_x0, exp_fwd_wb, exp_snoop;

      vecs[0] = '{4'b1001, 32'h0000_0001, 32'h0000_0055, 32'h0000_0024, 1'b1, 1'b1, 5'd3,  32'h100,
                  32'h0000_0001, 32'h0000_0024, 5'd4, 1'b1};
      vecs[1] = '{4'b1000, 32'h8000_0000, 32'h0000_0123, 32'h0000_0007, 1'b0, 1'b1, 5'd4,  32'h104,
                  32'h8000_0000, 32'h0000_0123, 5'd3, 1'b1};
      vecs[2] = '{4'b1010, 32'hF0F0_F0F0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd5,  32'h108,
                  32'hF0F0_F0F0, 32'hFFFF_FFFF, 5'd31, 1'b0};
      vecs[3] = '{4'b0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0020, 1'b0, 1'b1, 5'd31, 32'h10C,
                  32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b1};
      vecs[4] = '{4'b0111, 32'h0000_0000, 32'hFFFF_FFE0, 32'h0000_0040, 1'b1, 1'b1, 5'd0,  32'h110,
                  32'h0000_0000, 32'h0000_0040, 5'd0, 1'b1};

      applyStimulus(idle_stim());
      #2;
      checkZero("reset");

      @(negedge clk);
      rst_n = 1'b1;

      // Table of single captures with the consumer always ready.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s = idle_stim();
         s.in_valid  = 1'b1;
         s.sel       = vecs[i].sel;
         s.rs1_data  = vecs[i].rs1_data;
         s.rs2_data  = vecs[i].rs2_data;
         s.imm       = vecs[i].imm;
         s.use_imm   = vecs[i].use_imm;
         s.reg_write = vecs[i].reg_write;
         s.rd        = vecs[i].rd;
         s.pc        = vecs[i].pc;
         applyStimulus(s);
         #1 checkVal("vec.in_ready", 32'(in_ready), 32'd1);
         tick();
         checkVal("vec.out_valid", 32'(out_valid), 32'd1);
         checkVal("vec.out_a", out_a, vecs[i].exp_a);
         checkVal("vec.out_b", out_b, vecs[i].exp_b);
         checkVal("vec.out_shamt", 32'(out_shamt), 32'(vecs[i].exp_shamt));
         checkVal("vec.out_reg_write", 32'(out_reg_write), 32'(vecs[i].exp_rw));
         checkVal("vec.out_sel", 32'(out_sel), 32'(vecs[i].sel));
         checkVal("vec.out_rd", 32'(out_rd), 32'(vecs[i].rd));
         checkVal("vec.out_pc", out_pc, vecs[i].pc);
      end

      // Drain: entry empties, reg_write drops, data holds.
      @(negedge clk);
      applyStimulus(idle_stim());
      tick();
      checkVal("drain.out_valid", 32'(out_valid), 32'd0);
      checkVal("drain.out_reg_write", 32'(out_reg_write), 32'd0);
      checkVal("drain.out_pc_hold", out_pc, 32'h110);

      // Stall for three cycles with a new instruction waiting, then release.
      @(negedge clk);
      s = idle_stim();
      s.in_valid = 1'b1; s.rs1_data = 32'h0000_00A1; s.reg_write = 1'b1; s.rd = 5'd6; s.pc = 32'h200;
      applyStimulus(s);
      tick();
      checkVal("stall.load_a", out_a, 32'h0000_00A1);
      @(negedge clk);
      s.out_ready = 1'b0; s.rs1_data = 32'h0000_00B2; s.pc = 32'h204; s.rd = 5'd7;
      applyStimulus(s);
      repeat (3) begin
         #1 checkVal("stall.in_ready", 32'(in_ready), 32'd0);
         tick();
         checkVal("stall.out_valid", 32'(out_valid), 32'd1);
         checkVal("stall.out_a", out_a, 32'h0000_00A1);
         checkVal("stall.out_pc", out_pc, 32'h200);
         checkOutput("stall");
         @(negedge clk);
      end
      s.out_ready = 1'b1;
      applyStimulus(s);
      #1 checkVal("release.in_ready", 32'(in_ready), 32'd1);
      tick();
      checkVal("release.out_valid", 32'(out_valid), 32'd1);
      checkVal("release.out_a", out_a, 32'h0000_00B2);
      checkVal("release.out_rd", 32'(out_rd), 32'd7);

      // Flush with a ready consumer and an offered instruction.
      @(negedge clk);
      s.flush = 1'b1; s.rs1_data = 32'h0000_00C3; s.pc = 32'h208;
      applyStimulus(s);
      #1 checkVal("flush.in_ready", 32'(in_ready), 32'd0);
      tick();
      checkVal("flush.out_valid", 32'(out_valid), 32'd0);
      checkVal("flush.out_reg_write", 32'(out_reg_write), 32'd0);
      checkVal("flush.out_a_hold", out_a, 32'h0000_00B2);
      checkOutput("flush");

      // Reset pulsed during a stall, then capture on the first edge after.
      @(negedge clk);
      s = idle_stim();
      s.in_valid = 1'b1; s.rs1_data = 32'h0000_00D4; s.reg_write = 1'b1; s.pc = 32'h300; s.sel = 4'b1010;
      applyStimulus(s);
      tick();
      @(negedge clk);
      s.out_ready = 1'b0; s.rs1_data = 32'h0000_00E5;
      applyStimulus(s);
      tick();
      checkVal("prereset.out_valid", 32'(out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1 checkZero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkVal("postreset.out_valid", 32'(out_valid), 32'd1);
      checkVal("postreset.out_a", out_a, 32'h0000_00E5);
      checkOutput("postreset");

      // Forwarding and snoop corners.
`ifdef EX_OPERAND_FWD_EN
      exp_fwd_mem = 32'hAAAA_0000;
      exp_fwd_x0  = 32'h0000_0000;
      exp_fwd_wb  = 32'h0000_0077;
      exp_snoop   = 32'hDEAD_BEEF;
`else
      exp_fwd_mem = 32'h1111_0000;
      exp_fwd_x0  = 32'h0000_5555;
      exp_fwd_wb  = 32'h0000_6666;
      exp_snoop   = 32'h0BAD_0000;
`endif
      @(negedge clk);
      s = idle_stim();
      s.in_valid = 1'b1; s.rs1 = 5'd5; s.rs1_data = 32'h1111_0000;
      s.mem_we = 1'b1; s.mem_rd = 5'd5; s.mem_data = 32'hAAAA_0000;
      s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'h0000_1234;
      applyStimulus(s);
      tick();
      checkVal("fwd_mem.out_a", out_a, exp_fwd_mem);
      @(negedge clk);
      s.rs1 = 5'd0; s.rs1_data = 32'h0000_5555; s.mem_rd = 5'd0; s.wb_rd = 5'd0;
      applyStimulus(s);
      tick();
      checkVal("fwd_x0.out_a", out_a, exp_fwd_x0);
      @(negedge clk);
      s.rs1 = 5'd9; s.rs1_data = 32'h0000_6666; s.mem_rd = 5'd3; s.wb_rd = 5'd9; s.wb_data = 32'h0000_0077;
      applyStimulus(s);
      tick();
      checkVal("fwd_wb.out_a", out_a, exp_fwd_wb);
      @(negedge clk);
      s = idle_stim();
      s.in_valid = 1'b1; s.rs2 = 5'd7; s.rs2_data = 32'h0BAD_0000;
      applyStimulus(s);
      tick();
      checkVal("snoop.load_b", out_b, 32'h0BAD_0000);
      @(negedge clk);
      s = idle_stim();
      s.out_ready = 1'b0; s.wb_we = 1'b1; s.wb_rd = 5'd7; s.wb_data = 32'hDEAD_BEEF;
      applyStimulus(s);
      tick();
      checkVal("snoop.out_b", out_b, exp_snoop);
      checkOutput("snoop");

      // Randomized run against the model.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         s.in_valid  = ($urandom_range(0, 9) < 7);
         s.out_ready = ($urandom_range(0, 9) < 6);
         s.flush     = ($urandom_range(0, 19) == 0);
         s.pc        = $urandom;
         s.imm       = $urandom;
         s.rs1       = 5'($urandom_range(0, 7));
         s.rs2       = 5'($urandom_range(0, 7));
         s.rd        = 5'($urandom_range(0, 31));
         s.rs1_data  = $urandom;
         s.rs2_data  = $urandom;
         s.sel       = 4'($urandom_range(0, 15));
         s.use_imm   = 1'($urandom_range(0, 1));
         s.reg_write = 1'($urandom_range(0, 1));
         s.mem_we    = 1'($urandom_range(0, 1));
         s.mem_rd    = 5'($urandom_range(0, 7));
         s.mem_data  = $urandom;
         s.wb_we     = 1'($urandom_range(0, 1));
         s.wb_rd     = 5'($urandom_range(0, 7));
         s.wb_data   = $urandom;
         applyStimulus(s);
         #1 checkVal("rand.in_ready", 32'(in_ready), 32'(model_in_ready(m)));
         tick();
         checkOutput("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Port list SHALL be, clock and reset first (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  decode stage offers an instruction.
REQ-005 in_ready  out  1  stage can accept this cycle.
REQ-006 in_pc, in_imm  in  32 each  PC and sign-extended immediate.
REQ-007 in_rs1, in_rs2, in_rd  in  5 each  register addresses.
REQ-008 in_rs1_data, in_rs2_data  in  32 each  register-file read data.
REQ-009 in_sel  in  4  ALU/shifter op code; 1000 SRL, 1001 SLL, 1010 SRA, others ALU.
REQ-010 in_use_imm, in_reg_write  in  1 each  B-operand select; writeback enable.
REQ-011 flush  in  1  kill held and incoming instruction.
REQ-012 mem_we, mem_rd, mem_data  in  1/5/32  EX/MEM forwarding source.
REQ-013 wb_we, wb_rd, wb_data  in  1/5/32  MEM/WB forwarding source.
REQ-014 out_valid  out  1  held instruction present; out_ready  in  1  EX consumes.
REQ-015 out_a, out_b  out  32 each  operands to ALU/shifter.
REQ-016 out_shamt  out  5  shift amount; out_sel  out  4; out_rd  out  5; out_reg_write  out  1; out_pc  out  32.

Function
REQ-017 Single-entry register; in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-018 Capture SHALL occur when in_valid && in_ready; out_valid rises next cycle (latency 1).
REQ-019 out_valid && out_ready with no capture SHALL clear out_valid next cycle; with capture, register reloads, out_valid stays 1 (back-to-back, full throughput).
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable except snoop updates of REQ-024.
REQ-021 Captured rs1 value: mem_data if mem_we && mem_rd==in_rs1 && in_rs1!=0; else wb_data if wb_we && wb_rd==in_rs1 && in_rs1!=0; else in_rs1_data; same rule for rs2.
REQ-022 MEM forward SHALL take priority over WB when both match; register x0 SHALL never be forwarded and its value SHALL read 0.
REQ-023 out_a = stored rs1 value; out_b = out_use_imm ? stored imm : stored rs2 value.
REQ-024 While holding, if wb_we && wb_rd==held rs1 (rs2) && address!=0, stored rs1 (rs2) value SHALL update to wb_data next cycle.
REQ-025 out_shamt SHALL equal out_b[4:0]; upper bits of out_b ignored for shifts.
REQ-026 flush SHALL clear out_valid next cycle and SHALL block capture that cycle, regardless of in_valid/out_ready.
REQ-027 When out_valid=0, out_reg_write SHALL read 0; other data outputs hold last values.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_reg_write=0, out_a=out_b=out_pc=0, out_sel=0000, out_rd=0, out_shamt=0.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; first capture SHALL be possible on the first edge after rst_n deasserts.

Configuration
REQ-030 Macro EX_OPERAND_FWD_EN: defined SHALL enable REQ-021, REQ-022 forwarding and REQ-024 snooping.
REQ-031 Undefined: operands SHALL be in_rs1_data/in_rs2_data captured raw, no snoop; mem_*/wb_* ports remain present and are ignored.

Verification
REQ-032 Reset then in_valid=1, in_sel=1001, in_rs1_data=0x00000001, in_imm=0x00000024, in_use_imm=1 -> next cycle out_valid=1, out_a=0x1, out_shamt=4.
REQ-033 (FWD_EN) in_rs1=5, mem_we=1 mem_rd=5 mem_data=0xAAAA0000, wb_we=1 wb_rd=5 wb_data=0x1234 -> out_a=0xAAAA0000; repeat with in_rs1=0 -> out_a=0.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready -> new instruction captured same edge, out_valid stays 1.
REQ-035 (FWD_EN) held rs2=7, stalled, wb_we=1 wb_rd=7 wb_data=0xDEADBEEF, in_use_imm=0 -> out_b=0xDEADBEEF next cycle.
REQ-036 flush=1 with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0 next cycle, out_reg_write=0.
REQ-037 rst_n pulsed low during stall -> out_valid=0 immediately, all outputs zero.
